// File: rtl/fixed_point_divider_if.sv
// Operand/result handshake bundle for fixed_point_divider.
// The master drives operands and out_ready; the slave (the divider) drives the rest.
interface fixed_point_divider_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic             overflow;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, overflow, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, overflow, div_by_zero
  );
endinterface

// File: rtl/fixed_point_divider.sv
// Sequential signed fixed-point divider, radix-2 restoring, one quotient bit per clock.
// Define FIXED_DIV_ROUND_NEAREST_EN for round-half-away-from-zero (one extra iteration).
module fixed_point_divider #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned FRAC  = 6
) (
  input logic                  clk,
  input logic                  rst_n,
  fixed_point_divider_if.slave bus
);

`ifdef FIXED_DIV_ROUND_NEAREST_EN
  localparam int unsigned SHIFT = FRAC + 1;
`else
  localparam int unsigned SHIFT = FRAC;
`endif
  localparam int unsigned ITER = WIDTH + SHIFT;
  localparam int unsigned CW   = $clog2(ITER + 1);

  localparam logic [ITER-1:0]  MAX_POS_MAG = ITER'((1 << (WIDTH - 1)) - 1);
  localparam logic [ITER-1:0]  MAX_NEG_MAG = ITER'(1 << (WIDTH - 1));
  localparam logic [WIDTH-1:0] SAT_POS     = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG     = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  state_t state;
  state_t next_state;

  logic [ITER-1:0]  num;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] den;
  logic [ITER-1:0]  q;
  logic [CW-1:0]    cnt;
  logic             neg;
  logic             dvd_neg;

  logic [WIDTH-1:0] quotient_r;
  logic             overflow_r;
  logic             div_by_zero_r;
  logic             out_valid_r;

  logic             accept;
  logic             den_zero;
  logic             last_iter;
  logic [WIDTH-1:0] abs_dividend;
  logic [WIDTH-1:0] abs_divisor;
  logic [WIDTH:0]   rem_shift;
  logic             fits;
  logic [WIDTH-1:0] rem_next;
  logic [ITER-1:0]  mag;
  logic [WIDTH-1:0] fix_q;
  logic             fix_ovf;

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = out_valid_r;
  assign bus.quotient    = quotient_r;
  assign bus.overflow    = overflow_r;
  assign bus.div_by_zero = div_by_zero_r;

  assign accept    = bus.in_valid && (state == IDLE);
  assign den_zero  = (den == '0);
  assign last_iter = (cnt == CW'(ITER - 1));

  always_comb begin
    abs_dividend = bus.dividend;
    abs_divisor  = bus.divisor;
    if (bus.dividend[WIDTH-1]) abs_dividend = -bus.dividend;
    if (bus.divisor[WIDTH-1])  abs_divisor  = -bus.divisor;
  end

  // Working remainder is WIDTH+1 bits; after a restore it is always below den, so
  // only WIDTH bits need to be stored between iterations.
  always_comb begin
    rem_shift = {rem, num[ITER-1]};
    fits      = (rem_shift >= {1'b0, den});
    rem_next  = rem_shift[WIDTH-1:0];
    if (fits) rem_next = WIDTH'(rem_shift - {1'b0, den});
  end

  always_comb begin
`ifdef FIXED_DIV_ROUND_NEAREST_EN
    mag = {1'b0, q[ITER-1:1]} + ITER'(q[0]);
`else
    mag = q;
`endif
    fix_q   = '0;
    fix_ovf = 1'b0;
    if (den_zero) begin
      fix_q = dvd_neg ? SAT_NEG : SAT_POS;
    end else if (neg) begin
      if (mag > MAX_NEG_MAG) begin
        fix_q   = SAT_NEG;
        fix_ovf = 1'b1;
      end else begin
        fix_q = -mag[WIDTH-1:0];
      end
    end else begin
      if (mag > MAX_POS_MAG) begin
        fix_q   = SAT_POS;
        fix_ovf = 1'b1;
      end else begin
        fix_q = mag[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // A zero divisor is detected on the first BUSY cycle and skips every iteration,
  // giving the two-cycle divide-by-zero turnaround.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (bus.in_valid) next_state = BUSY;
      BUSY: if (den_zero || last_iter) next_state = FIX;
      FIX:  next_state = DONE;
      DONE: if (bus.out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num           <= '0;
      rem           <= '0;
      den           <= '0;
      q             <= '0;
      cnt           <= '0;
      neg           <= 1'b0;
      dvd_neg       <= 1'b0;
      quotient_r    <= '0;
      overflow_r    <= 1'b0;
      div_by_zero_r <= 1'b0;
      out_valid_r   <= 1'b0;
    end else begin
      if (accept) begin
        num     <= ITER'(abs_dividend) << SHIFT;
        den     <= abs_divisor;
        rem     <= '0;
        q       <= '0;
        cnt     <= '0;
        neg     <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
        dvd_neg <= bus.dividend[WIDTH-1];
      end
      if (state == BUSY && !den_zero) begin
        rem <= rem_next;
        num <= num << 1;
        q   <= {q[ITER-2:0], fits};
        cnt <= cnt + 1'b1;
      end
      if (state == FIX) begin
        quotient_r    <= fix_q;
        overflow_r    <= fix_ovf;
        div_by_zero_r <= den_zero;
        out_valid_r   <= 1'b1;
      end
      if (state == DONE && bus.out_ready) begin
        out_valid_r   <= 1'b0;
        overflow_r    <= 1'b0;
        div_by_zero_r <= 1'b0;
      end
    end
  end

endmodule
